// File: rtl/axis_fcs_checker.sv
// axis_fcs_checker: validates CRC-32 FCS and length of byte-wide frames, strips the FCS and
// flags bad frames on the last payload beat. Define AXIS_FCS_CHECKER_STATS_EN for frame counters.
module axis_fcs_checker #(
  parameter int AXIS_USER_BITS = 1,
  parameter int MIN_BYTES      = 64,
  parameter int MAX_BYTES      = 1518,
  parameter int CNT_BITS       = 32
) (
  input  logic                      i_clk,
  input  logic                      i_sreset,
  input  logic                      i_valid,
  input  logic                      i_last,
  input  logic [7:0]                i_data,
  input  logic [AXIS_USER_BITS-1:0] i_user,
  input  logic                      i_error,
  output logic                      o_valid,
  output logic                      o_last,
  output logic [7:0]                o_data,
  output logic [AXIS_USER_BITS-1:0] o_user,
  output logic                      o_error,
  output logic [CNT_BITS-1:0]       o_good_count,
  output logic [CNT_BITS-1:0]       o_bad_count
);
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [15:0] MIN_LEN     = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_LEN     = 16'(MAX_BYTES);

  typedef enum logic [1:0] {HUNT, IDLE, FRAME} state_t;

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next, crc_upd;
  logic [15:0] len_reg, len_next, len_upd;
  logic        err_reg, err_next, err_upd;
  logic [2:0]  cnt_reg, cnt_next;
  logic        shift_en, emit, emit_last, emit_error, frame_bad;

  logic [7:0]                line_data_reg [4];
  logic [AXIS_USER_BITS-1:0] line_user_reg [4];

  logic                      o_valid_reg, o_last_reg, o_error_reg;
  logic [7:0]                o_data_reg;
  logic [AXIS_USER_BITS-1:0] o_user_reg;

  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    len_next   = len_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    shift_en   = 1'b0;
    emit       = 1'b0;
    emit_last  = 1'b0;
    emit_error = 1'b0;
    crc_upd    = crc_byte(crc_reg, i_data);
    len_upd    = (&len_reg) ? len_reg : len_reg + 16'd1;
    err_upd    = err_reg | i_error;
    frame_bad  = err_upd | (crc_upd != CRC_RESIDUE) | (len_upd < MIN_LEN) | (len_upd > MAX_LEN);
    if (i_valid) begin
      case (state_reg)
        HUNT: if (i_last) state_next = IDLE;
        IDLE: begin
          crc_next   = crc_byte(CRC_INIT, i_data);
          len_next   = 16'd1;
          err_next   = i_error;
          shift_en   = 1'b1;
          cnt_next   = 3'd1;
          state_next = FRAME;
          // A one-byte frame is dropped on the spot.
          if (i_last) begin
            cnt_next   = 3'd0;
            state_next = IDLE;
          end
        end
        FRAME: begin
          crc_next = crc_upd;
          len_next = len_upd;
          err_next = err_upd;
          shift_en = 1'b1;
          if (cnt_reg == 3'd4) emit = 1'b1;
          else                 cnt_next = cnt_reg + 3'd1;
          if (i_last) begin
            // The four held bytes are the FCS; drop them.
            cnt_next   = 3'd0;
            state_next = IDLE;
            emit_last  = (cnt_reg == 3'd4);
            emit_error = (cnt_reg == 3'd4) & frame_bad;
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sreset) begin
      state_reg <= HUNT;
      crc_reg   <= CRC_INIT;
      len_reg   <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      len_reg   <= len_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Index 0 is the newest byte, index 3 the oldest.
  always_ff @(posedge i_clk) begin
    if (i_sreset) begin
      for (int i = 0; i < 4; i++) begin
        line_data_reg[i] <= '0;
        line_user_reg[i] <= '0;
      end
    end else if (shift_en) begin
      line_data_reg[0] <= i_data;
      line_user_reg[0] <= i_user;
      for (int i = 1; i < 4; i++) begin
        line_data_reg[i] <= line_data_reg[i-1];
        line_user_reg[i] <= line_user_reg[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_sreset) begin
      o_valid_reg <= 1'b0;
      o_last_reg  <= 1'b0;
      o_error_reg <= 1'b0;
      o_data_reg  <= '0;
      o_user_reg  <= '0;
    end else begin
      o_valid_reg <= emit;
      o_last_reg  <= emit_last;
      o_error_reg <= emit_error;
      if (emit) begin
        o_data_reg <= line_data_reg[3];
        o_user_reg <= line_user_reg[3];
      end
    end
  end

  assign o_valid = o_valid_reg;
  assign o_last  = o_last_reg;
  assign o_error = o_error_reg;
  assign o_data  = o_data_reg;
  assign o_user  = o_user_reg;

`ifdef AXIS_FCS_CHECKER_STATS_EN
  logic                frame_done, frame_good;
  logic [CNT_BITS-1:0] good_count_reg, bad_count_reg;

  // Frames too short to emit a beat never set emit_last, so they land in bad.
  assign frame_done = i_valid & i_last & (state_reg != HUNT);
  assign frame_good = emit_last & ~frame_bad;

  always_ff @(posedge i_clk) begin
    if (i_sreset) begin
      good_count_reg <= '0;
      bad_count_reg  <= '0;
    end else if (frame_done) begin
      if (frame_good) good_count_reg <= good_count_reg + 1'b1;
      else            bad_count_reg  <= bad_count_reg + 1'b1;
    end
  end

  assign o_good_count = good_count_reg;
  assign o_bad_count  = bad_count_reg;
`else
  assign o_good_count = '0;
  assign o_bad_count  = '0;
`endif

endmodule

// File: tb/tb_axis_fcs_checker.sv
// Bench for axis_fcs_checker: two instances (short and default length limits) checked per cycle
// against a frame-level reference model, plus a table of directed frames and a mid-frame reset.
`timescale 1ns/1ps
module tb_axis_fcs_checker;
  localparam int D1_MIN = 1;
  localparam int D1_MAX = 40;
  localparam int D2_MIN = 64;
  localparam int D2_MAX = 1518;
`ifdef AXIS_FCS_CHECKER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0, srst = 1'b1, valid = 1'b0, last = 1'b0, err_in = 1'b0;
  logic [7:0] data = 8'h00;
  logic [0:0] user = 1'b0;

  logic v1, l1, e1, v2, l2, e2;
  logic [7:0] d1, d2;
  logic [0:0] u1, u2;
  logic [31:0] g1, b1, g2, b2;

  axis_fcs_checker #(.AXIS_USER_BITS(1), .MIN_BYTES(D1_MIN), .MAX_BYTES(D1_MAX), .CNT_BITS(32)) dut (
    .i_clk(clk), .i_sreset(srst), .i_valid(valid), .i_last(last), .i_data(data), .i_user(user),
    .i_error(err_in), .o_valid(v1), .o_last(l1), .o_data(d1), .o_user(u1), .o_error(e1),
    .o_good_count(g1), .o_bad_count(b1));

  axis_fcs_checker #(.AXIS_USER_BITS(1)) dut_def (
    .i_clk(clk), .i_sreset(srst), .i_valid(valid), .i_last(last), .i_data(data), .i_user(user),
    .i_error(err_in), .o_valid(v2), .o_last(l2), .o_data(d2), .o_user(u2), .o_error(e2),
    .o_good_count(g2), .o_bad_count(b2));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit          m_hunt = 1'b1;
  logic [7:0]  fq[$];
  logic [0:0]  uq[$];
  bit          f_err;
  bit          x_v, x_l, x_e1, x_e2;
  logic [7:0]  x_d;
  logic [0:0]  x_u;
  int unsigned m_good1 = 0, m_bad1 = 0, m_good2 = 0, m_bad2 = 0;

  // per-frame tallies of DUT behaviour
  int beats1, lasts1;
  bit last_err1, last_err2;

  typedef logic [7:0] blk_t [16];
  typedef struct {
    blk_t b;
    int   n;
    int   err_idx;
    int   gap_idx;
    int   gap_len;
    int   exp_beats;
    bit   exp_e1;
    bit   exp_e2;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_of(input logic [7:0] q[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Expected outputs for the edge just taken, from frame-level rules.
  task automatic model_step();
    int n;
    bit crc_bad, bad1, bad2;
    x_v = 0; x_l = 0; x_e1 = 0; x_e2 = 0;
    if (srst) begin
      m_hunt = 1'b1;
      fq.delete();
      uq.delete();
      m_good1 = 0; m_bad1 = 0; m_good2 = 0; m_bad2 = 0;
    end else if (valid) begin
      if (m_hunt) begin
        if (last) m_hunt = 1'b0;
      end else begin
        if (fq.size() == 0) f_err = 1'b0;
        fq.push_back(data);
        uq.push_back(user);
        f_err = f_err | err_in;
        n = fq.size();
        if (n >= 5) begin
          x_v = 1'b1;
          x_d = fq[n-5];
          x_u = uq[n-5];
        end
        if (last) begin
          crc_bad = 1'b1;
          if (n >= 4) crc_bad = (crc_of(fq, n - 4) != {fq[n-1], fq[n-2], fq[n-3], fq[n-4]});
          bad1 = f_err || crc_bad || n < D1_MIN || n > D1_MAX || n <= 4;
          bad2 = f_err || crc_bad || n < D2_MIN || n > D2_MAX || n <= 4;
          if (n >= 5) begin
            x_l = 1'b1; x_e1 = bad1; x_e2 = bad2;
          end
          if (bad1) m_bad1++; else m_good1++;
          if (bad2) m_bad2++; else m_good2++;
          fq.delete();
          uq.delete();
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input bit l, input logic [7:0] d, input logic [0:0] u, input bit e);
    valid = v; last = l; data = d; user = u; err_in = e;
    @(posedge clk);
    model_step();
    #1;
    chk("cycle_dut", 32'({v1, l1, e1, v1 ? {d1, u1} : 9'h0}), 32'({x_v, x_l, x_e1, x_v ? {x_d, x_u} : 9'h0}));
    chk("cycle_dut_def", 32'({v2, l2, e2, v2 ? {d2, u2} : 9'h0}), 32'({x_v, x_l, x_e2, x_v ? {x_d, x_u} : 9'h0}));
    $display("t=%0t in v=%0b l=%0b d=%h | dut v=%0b l=%0b d=%h e=%0b | def v=%0b e=%0b",
             $time, v, l, d, v1, l1, d1, e1, v2, e2);
    if (v1) beats1++;
    if (l1) begin lasts1++; last_err1 = e1; end
    if (l2) last_err2 = e2;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] b[$], input int err_idx, input int gap_idx,
                            input int gap_len, input bit rand_gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (i == gap_idx) repeat (gap_len) idle_cycle();
      if (rand_gaps && $urandom_range(0, 5) == 0) idle_cycle();
      cycle(1'b1, 1'(i == b.size() - 1), b[i], 1'($urandom_range(0, 1)), 1'(i == err_idx));
    end
  endtask

  task automatic build_frame(input int plen, input bit corrupt, output logic [7:0] q[$]);
    logic [31:0] c;
    int idx;
    q.delete();
    for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
    c = crc_of(q, plen);
    q.push_back(c[7:0]); q.push_back(c[15:8]); q.push_back(c[23:16]); q.push_back(c[31:24]);
    if (corrupt) begin
      idx = $urandom_range(0, q.size() - 1);
      q[idx] = q[idx] ^ (8'h01 << $urandom_range(0, 7));
    end
  endtask

  function automatic void clear_tally();
    beats1 = 0; lasts1 = 0; last_err1 = 1'b0; last_err2 = 1'b0;
  endfunction

  blk_t good_b  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                    8'h26, 8'h39, 8'hF4, 8'hCB, 8'h00, 8'h00, 8'h00};
  blk_t short_b = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  blk_t zero_b  = '{default: 8'h00};
  blk_t flip_b;
  vec_t tbl [7];

  initial begin
    logic [7:0] q[$];
    int plens [6] = '{36, 37, 59, 60, 1, 0};

    flip_b = good_b;
    flip_b[4] = 8'h36;
    //          bytes    n  err gap glen beats e1    e2
    tbl[0] = '{good_b,  13, -1, -1, 0,   9,  1'b0, 1'b1};
    tbl[1] = '{flip_b,  13, -1, -1, 0,   9,  1'b1, 1'b1};
    tbl[2] = '{short_b,  3, -1, -1, 0,   0,  1'b0, 1'b0};
    tbl[3] = '{good_b,  13, -1, -1, 0,   9,  1'b0, 1'b1};
    tbl[4] = '{good_b,  13,  2, -1, 0,   9,  1'b1, 1'b1};
    tbl[5] = '{good_b,  13, -1,  6, 3,   9,  1'b0, 1'b1};
    tbl[6] = '{zero_b,   4, -1, -1, 0,   0,  1'b0, 1'b0};

    srst = 1'b1;
    repeat (3) idle_cycle();
    chk("reset_outputs", 32'({v1, l1, e1, d1, u1}), 32'h0);
    chk("reset_outputs_def", 32'({v2, l2, e2, d2, u2}), 32'h0);
    chk("reset_good_count", g1, 32'h0);
    chk("reset_bad_count", b1, 32'h0);
    srst = 1'b0;
    idle_cycle();
    // Leave HUNT: this byte ends a frame that started before reset.
    cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);

    foreach (tbl[r]) begin
      q.delete();
      for (int i = 0; i < tbl[r].n; i++) q.push_back(tbl[r].b[i]);
      clear_tally();
      send_frame(q, tbl[r].err_idx, tbl[r].gap_idx, tbl[r].gap_len, 1'b0);
      chk($sformatf("vec%0d_beats", r), beats1, tbl[r].exp_beats);
      if (tbl[r].exp_beats > 0) begin
        chk($sformatf("vec%0d_lasts", r), lasts1, 1);
        chk($sformatf("vec%0d_error", r), 32'(last_err1), 32'(tbl[r].exp_e1));
        chk($sformatf("vec%0d_error_def", r), 32'(last_err2), 32'(tbl[r].exp_e2));
      end else begin
        chk($sformatf("vec%0d_lasts", r), lasts1, 0);
      end
    end
    idle_cycle();
    chk("table_good_count", g1, STATS ? 32'd3 : 32'd0);
    chk("table_bad_count", b1, STATS ? 32'd4 : 32'd0);
    chk("table_good_count_def", g2, 32'd0);
    chk("table_bad_count_def", b2, STATS ? 32'd7 : 32'd0);

    // Reset after byte 6, then the frame tail must be swallowed.
    q.delete();
    for (int i = 0; i < 13; i++) q.push_back(good_b[i]);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, q[i], 1'b0, 1'b0);
    srst = 1'b1;
    idle_cycle();
    srst = 1'b0;
    chk("midreset_outputs", 32'({v1, l1, e1, d1, u1}), 32'h0);
    chk("midreset_counts", g1 | b1, 32'h0);
    clear_tally();
    for (int i = 6; i < 13; i++) cycle(1'b1, 1'(i == 12), q[i], 1'b0, 1'b0);
    chk("hunt_tail_beats", beats1, 0);
    chk("hunt_tail_lasts", lasts1, 0);
    clear_tally();
    send_frame(q, -1, -1, 0, 1'b0);
    chk("after_reset_beats", beats1, 9);
    chk("after_reset_error", 32'(last_err1), 32'h0);

    // Length boundaries: 40/41 for the short instance, 63/64 for the default one, plus 5 and 4.
    foreach (plens[k]) begin
      build_frame(plens[k], 1'b0, q);
      send_frame(q, -1, -1, 0, 1'b0);
    end

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        q.delete();
        repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
      end else begin
        build_frame($urandom_range(0, 70), $urandom_range(0, 3) == 0, q);
      end
      send_frame(q, ($urandom_range(0, 7) == 0) ? $urandom_range(0, q.size() - 1) : -1, -1, 0, 1'b1);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end
    idle_cycle();
    chk("final_good_count", g1, STATS ? 32'(m_good1) : 32'd0);
    chk("final_bad_count", b1, STATS ? 32'(m_bad1) : 32'd0);
    chk("final_good_count_def", g2, STATS ? 32'(m_good2) : 32'd0);
    chk("final_bad_count_def", b2, STATS ? 32'(m_bad2) : 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
